// File: rtl/countdown_timer_pkg.sv
// -----------------------------------------------------------------------------
// countdown_timer_pkg
//   Shared definitions for the BCD countdown timer slice: default digit
//   geometry, FSM state encoding and a small state-decode helper.
//   Optional feature macro used by this slice: AUTO_RELOAD_EN.
// -----------------------------------------------------------------------------
package countdown_timer_pkg;

    localparam int unsigned NUM_DIGITS_DEF = 4;
    localparam int unsigned DIGIT_W_DEF    = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // States from which a start request may enter RUN.
    function automatic logic can_start(input state_t s);
        return (s == ST_IDLE) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// -----------------------------------------------------------------------------
// countdown_timer_if
//   Control/status bundle between the tick prescaler / front panel logic
//   (master) and the countdown timer core (slave).
//   Signals:
//     tick      single-cycle count strobe
//     start     begin/resume pulse
//     stop      pause pulse
//     load      load-preset pulse
//     preset    start value, packed BCD digits, digit 0 in LSBs
//     digit_max per-digit wrap value (e.g. 16'h5959 for MM:SS)
//     count     current value, packed digits
//     running   1 while counting
//     expired   1 while expired
//     done      one-cycle pulse on reaching zero
//   Related feature macro: AUTO_RELOAD_EN (affects core behaviour only).
// -----------------------------------------------------------------------------
interface countdown_timer_if
    import countdown_timer_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int unsigned DIGIT_W    = DIGIT_W_DEF
) ();

    logic                          tick;
    logic                          start;
    logic                          stop;
    logic                          load;
    logic [NUM_DIGITS*DIGIT_W-1:0] preset;
    logic [NUM_DIGITS*DIGIT_W-1:0] digit_max;
    logic [NUM_DIGITS*DIGIT_W-1:0] count;
    logic                          running;
    logic                          expired;
    logic                          done;

    modport master (
        output tick, start, stop, load, preset, digit_max,
        input  count, running, expired, done
    );

    modport slave (
        input  tick, start, stop, load, preset, digit_max,
        output count, running, expired, done
    );

endinterface

// File: rtl/countdown_timer_decrease_digit.sv
// -----------------------------------------------------------------------------
// decrease_digit
//   One digit of the countdown chain. Holds the digit register and computes
//   its decremented value with borrow propagation.
//   Ports:
//     clk        system clock
//     rst        asynchronous active-high reset (digit -> 0)
//     load       load load_val into the digit (has priority over borrow)
//     load_val   value to load
//     max_num    wrap value used when decrementing from 0
//     borrow_in  decrement request from the lower digit (or the tick)
//     digit      registered digit value
//     digit_dec  combinational next value if no load occurs
//     borrow_out combinational borrow to the next-higher digit
//   Part of the countdown_timer slice (feature macro AUTO_RELOAD_EN lives in
//   the top).
// -----------------------------------------------------------------------------
module decrease_digit
    import countdown_timer_pkg::*;
#(
    parameter int unsigned DIGIT_W = DIGIT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic [DIGIT_W-1:0] max_num,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] digit_dec,
    output logic               borrow_out
);

    logic digit_is_zero;

    // Out-of-range digits (> max_num) are not clamped: they simply count
    // down and only wrap to max_num after passing 0.
    always_comb begin
        digit_is_zero = (digit == '0);
        borrow_out    = borrow_in && digit_is_zero;
        digit_dec     = digit;
        if (borrow_in) begin
            if (digit_is_zero) begin
                digit_dec = max_num;
            end else begin
                digit_dec = digit - DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_val;
        end else begin
            digit <= digit_dec;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   Multi-digit BCD countdown timer. Loads a preset, decrements one step per
//   qualified tick with per-digit wrap limits, and signals expiry at zero.
//   Ports:
//     clk   system clock, all state on posedge
//     rst   asynchronous active-high reset
//     bus   countdown_timer_if.slave: tick/start/stop/load/preset/digit_max
//           in, count/running/expired/done out
//   Command priority per cycle: load > stop > start > tick.
//   Optional feature macro: AUTO_RELOAD_EN -- on reaching zero the preset is
//   reloaded and counting continues (done still pulses); a zero preset at
//   reload time still expires.
// -----------------------------------------------------------------------------
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int unsigned DIGIT_W    = DIGIT_W_DEF
) (
    input logic               clk,
    input logic               rst,
    countdown_timer_if.slave  bus
);

    localparam int unsigned CW = NUM_DIGITS * DIGIT_W;

    state_t          state;
    logic            running_q;
    logic            expired_q;
    logic            done_q;

    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_dec;
    logic [NUM_DIGITS:0] borrow;
    logic            borrow_unused;

    logic            tick_take;
    logic            zero_next;
    logic            reload_take;
    logic            digit_load;

    // A tick only acts in RUN and loses to load and stop in the same cycle.
    // Start is never taken in RUN, so it does not need to mask the tick here.
    always_comb begin
        tick_take = bus.tick && (state == ST_RUN) && !bus.load && !bus.stop;
        zero_next = (count_dec == '0);
`ifdef AUTO_RELOAD_EN
        reload_take = tick_take && zero_next && (bus.preset != '0);
`else
        reload_take = 1'b0;
`endif
        digit_load = bus.load || reload_take;
    end

    assign borrow[0] = tick_take;

    // Borrow out of the top digit would only occur when decrementing an
    // all-zero count, which RUN never holds.
    assign borrow_unused = borrow[NUM_DIGITS];

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        decrease_digit #(
            .DIGIT_W (DIGIT_W)
        ) u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (digit_load),
            .load_val   (bus.preset[i*DIGIT_W +: DIGIT_W]),
            .max_num    (bus.digit_max[i*DIGIT_W +: DIGIT_W]),
            .borrow_in  (borrow[i]),
            .digit      (count_q[i*DIGIT_W +: DIGIT_W]),
            .digit_dec  (count_dec[i*DIGIT_W +: DIGIT_W]),
            .borrow_out (borrow[i+1])
        );
    end

    // Without reload, the zero-reaching decrement itself leaves the digits at
    // 0, so no separate clear path is needed for the EXPIRED count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                state     <= ST_IDLE;
                running_q <= 1'b0;
                expired_q <= 1'b0;
            end else if (bus.stop && (state == ST_RUN)) begin
                state     <= ST_PAUSE;
                running_q <= 1'b0;
            end else if (bus.start && can_start(state) && (count_q != '0)) begin
                state     <= ST_RUN;
                running_q <= 1'b1;
            end else if (tick_take && zero_next) begin
                done_q <= 1'b1;
                if (!reload_take) begin
                    state     <= ST_EXPIRED;
                    running_q <= 1'b0;
                    expired_q <= 1'b1;
                end
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.expired = expired_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//   Directed, table-driven bench for countdown_timer (4 digits x 4 bits,
//   digit_max 16'h5959). Each table row is one clock cycle of inputs plus the
//   outputs expected just after that edge. Hand sequences cover async reset
//   and, with AUTO_RELOAD_EN defined, the reload behaviour.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    countdown_timer_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus ();

    countdown_timer #(
        .NUM_DIGITS (4),
        .DIGIT_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tick;
        logic        start;
        logic        stop;
        logic        load;
        logic [15:0] preset;
        logic [15:0] exp_count;
        logic        exp_running;
        logic        exp_expired;
        logic        exp_done;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic t, input logic s, input logic p,
                                input logic l, input logic [15:0] pre,
                                input logic [15:0] cnt, input logic r,
                                input logic e, input logic d);
        vec_t v;
        v.tick = t; v.start = s; v.stop = p; v.load = l; v.preset = pre;
        v.exp_count = cnt; v.exp_running = r; v.exp_expired = e; v.exp_done = d;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [15:0] cnt,
                             input logic r, input logic e, input logic d);
        chk({nm, ".count"},   bus.count,          cnt);
        chk({nm, ".running"}, {15'd0, bus.running}, {15'd0, r});
        chk({nm, ".expired"}, {15'd0, bus.expired}, {15'd0, e});
        chk({nm, ".done"},    {15'd0, bus.done},    {15'd0, d});
    endtask

    // Drive one cycle of inputs, then sample 1ns after the rising edge.
    task automatic cyc(input logic t, input logic s, input logic p,
                       input logic l, input logic [15:0] pre);
        bus.tick = t; bus.start = s; bus.stop = p; bus.load = l; bus.preset = pre;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.load = 1'b0;
        bus.preset = 16'h0000;
        bus.digit_max = 16'h5959;

        //       t  s  p  l  preset    count     r  e  d
        vecs[0]  = mk(0, 0, 0, 1, 16'h0100, 16'h0100, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 16'h0100, 16'h0100, 1, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 16'h0100, 16'h0059, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 16'h0100, 16'h0059, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1, 16'h0002, 16'h0002, 0, 0, 0);
        vecs[5]  = mk(1, 1, 0, 0, 16'h0002, 16'h0002, 1, 0, 0);
        vecs[6]  = mk(1, 0, 0, 0, 16'h0002, 16'h0001, 1, 0, 0);
`ifdef AUTO_RELOAD_EN
        vecs[7]  = mk(1, 0, 0, 0, 16'h0002, 16'h0002, 1, 0, 1);
        vecs[8]  = mk(0, 0, 0, 0, 16'h0002, 16'h0002, 1, 0, 0);
        vecs[9]  = mk(1, 0, 0, 0, 16'h0002, 16'h0001, 1, 0, 0);
        vecs[10] = mk(0, 1, 0, 0, 16'h0002, 16'h0001, 1, 0, 0);
`else
        vecs[7]  = mk(1, 0, 0, 0, 16'h0002, 16'h0000, 0, 1, 1);
        vecs[8]  = mk(0, 0, 0, 0, 16'h0002, 16'h0000, 0, 1, 0);
        vecs[9]  = mk(1, 0, 0, 0, 16'h0002, 16'h0000, 0, 1, 0);
        vecs[10] = mk(0, 1, 0, 0, 16'h0002, 16'h0000, 0, 1, 0);
`endif
        vecs[11] = mk(0, 0, 0, 1, 16'h0010, 16'h0010, 0, 0, 0);
        vecs[12] = mk(0, 1, 0, 0, 16'h0010, 16'h0010, 1, 0, 0);
        vecs[13] = mk(1, 0, 1, 0, 16'h0010, 16'h0010, 0, 0, 0);
        vecs[14] = mk(1, 0, 0, 0, 16'h0010, 16'h0010, 0, 0, 0);
        vecs[15] = mk(0, 1, 0, 0, 16'h0010, 16'h0010, 1, 0, 0);
        vecs[16] = mk(1, 0, 0, 0, 16'h0010, 16'h0009, 1, 0, 0);
        vecs[17] = mk(1, 1, 0, 1, 16'h0123, 16'h0123, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[19] = mk(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[20] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[21] = mk(0, 0, 0, 1, 16'h1000, 16'h1000, 0, 0, 0);
        vecs[22] = mk(0, 1, 0, 0, 16'h1000, 16'h1000, 1, 0, 0);
        vecs[23] = mk(1, 0, 0, 0, 16'h1000, 16'h0959, 1, 0, 0);
        vecs[24] = mk(0, 0, 0, 1, 16'h0070, 16'h0070, 0, 0, 0);
        vecs[25] = mk(0, 1, 0, 0, 16'h0070, 16'h0070, 1, 0, 0);
        vecs[26] = mk(1, 0, 0, 0, 16'h0070, 16'h0069, 1, 0, 0);
        vecs[27] = mk(0, 0, 1, 0, 16'h0070, 16'h0069, 0, 0, 0);

        // Reset state, observed while rst is still asserted.
        #1;
        check_all("reset", 16'h0000, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].tick, vecs[i].start, vecs[i].stop, vecs[i].load, vecs[i].preset);
            check_all($sformatf("vec%0d", i), vecs[i].exp_count,
                      vecs[i].exp_running, vecs[i].exp_expired, vecs[i].exp_done);
        end
        cyc(0, 0, 0, 0, 16'h0000);

        // Asynchronous reset in the middle of a RUN cycle.
        cyc(0, 0, 0, 1, 16'h0123);
        cyc(0, 1, 0, 0, 16'h0123);
        cyc(0, 0, 0, 0, 16'h0123);
        check_all("pre_rst", 16'h0123, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 16'h0000, 0, 0, 0);
        #1;
        rst = 1'b0;
        cyc(1, 1, 0, 0, 16'h0123);
        check_all("post_rst", 16'h0000, 0, 0, 0);

`ifdef AUTO_RELOAD_EN
        begin
            logic [15:0] exp_seq [7];
            exp_seq[0] = 16'h0002; exp_seq[1] = 16'h0001; exp_seq[2] = 16'h0003;
            exp_seq[3] = 16'h0002; exp_seq[4] = 16'h0001; exp_seq[5] = 16'h0003;
            exp_seq[6] = 16'h0002;
            cyc(0, 0, 0, 1, 16'h0003);
            cyc(0, 1, 0, 0, 16'h0003);
            for (int k = 1; k <= 7; k++) begin
                cyc(1, 0, 0, 0, 16'h0003);
                check_all($sformatf("reload_tick%0d", k), exp_seq[k-1], 1, 0,
                          (k == 3) || (k == 6));
            end
            cyc(0, 0, 0, 0, 16'h0003);
            check_all("reload_end", 16'h0002, 1, 0, 0);
            // Zero preset at reload time expires instead of reloading.
            cyc(0, 0, 0, 1, 16'h0001);
            cyc(0, 1, 0, 0, 16'h0001);
            cyc(1, 0, 0, 0, 16'h0000);
            check_all("reload_zero", 16'h0000, 0, 1, 1);
            cyc(1, 1, 0, 0, 16'h0000);
            check_all("reload_zero_hold", 16'h0000, 0, 1, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
